axi_wr_arbiter: RTL and testbench

Round-robin write-path arbiter that lets `NUM_MASTERS` AXI write masters share the single write port (AW/W/B) of the `axi_dut` memory slave. It owns one burst at a time, from address accept through the final B handshake, and routes W beats and the B response by the latched grant. It sits between the bench or system masters and the slave write channels; the read path bypasses it.

---
 rtl/axi_pkg.sv | 32 +++
 rtl/axi_wr_arbiter_rr_picker.sv | 30 +++
 rtl/axi_wr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI write-path types and default field widths.
package axi_pkg;

  localparam int unsigned AXI_ADDR_WIDTH  = 16;
  localparam int unsigned AXI_DATA_WIDTH  = 32;
  localparam int unsigned AXI_LEN_WIDTH   = 8;
  localparam int unsigned AXI_SIZE_WIDTH  = 3;
  localparam int unsigned AXI_BURST_WIDTH = 2;
  localparam int unsigned AXI_RESP_WIDTH  = 2;
  localparam int unsigned AXI_ID_WIDTH    = 4;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    RESP = 2'b11
  } arb_state_t;

endpackage

// File: rtl/axi_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, ascending modulo N.
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IW'((32'(ptr) + k) % N);
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write port (AW/W/B) among NUM_MASTERS masters.
// Optional per-master grant counters when AXI_WR_ARB_STATS_EN is defined.
module axi_wr_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned NUM_MASTERS  = 2,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LEN_WIDTH    = 8,
  parameter int unsigned SIZE_WIDTH   = 3,
  parameter int unsigned BURST_WIDTH  = 2,
  parameter int unsigned RESP_WIDTH   = 2,
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned STROBE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                axi_ACLK,
  input  logic                                axi_ARESET,
  input  logic [NUM_MASTERS-1:0]              m_AWVALID,
  output logic [NUM_MASTERS-1:0]              m_AWREADY,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]     m_AWID,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_AWADDR,
  input  logic [NUM_MASTERS*LEN_WIDTH-1:0]    m_AWLEN,
  input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]   m_AWSIZE,
  input  logic [NUM_MASTERS*BURST_WIDTH-1:0]  m_AWBURST,
  input  logic [NUM_MASTERS-1:0]              m_WVALID,
  output logic [NUM_MASTERS-1:0]              m_WREADY,
  input  logic [NUM_MASTERS-1:0]              m_WLAST,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_WDATA,
  input  logic [NUM_MASTERS*STROBE_WIDTH-1:0] m_WSTRB,
  output logic [NUM_MASTERS-1:0]              m_BVALID,
  input  logic [NUM_MASTERS-1:0]              m_BREADY,
  output logic [NUM_MASTERS*ID_WIDTH-1:0]     m_BID,
  output logic [NUM_MASTERS*RESP_WIDTH-1:0]   m_BRESP,
  output logic                                s_AWVALID,
  input  logic                                s_AWREADY,
  output logic [ID_WIDTH-1:0]                 s_AWID,
  output logic [ADDR_WIDTH-1:0]               s_AWADDR,
  output logic [LEN_WIDTH-1:0]                s_AWLEN,
  output logic [SIZE_WIDTH-1:0]               s_AWSIZE,
  output logic [BURST_WIDTH-1:0]              s_AWBURST,
  output logic                                s_WVALID,
  input  logic                                s_WREADY,
  output logic [DATA_WIDTH-1:0]               s_WDATA,
  output logic [STROBE_WIDTH-1:0]             s_WSTRB,
  output logic                                s_WLAST,
  input  logic                                s_BVALID,
  output logic                                s_BREADY,
  input  logic [ID_WIDTH-1:0]                 s_BID,
  input  logic [RESP_WIDTH-1:0]               s_BRESP
`ifdef AXI_WR_ARB_STATS_EN
  ,
  output logic [NUM_MASTERS*16-1:0]           grant_cnt
`endif
);

  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_t               state_q, state_d;
  logic [IW-1:0]            owner_q, rr_ptr_q;
  logic [NUM_MASTERS-1:0]   pick_gnt;
  logic [IW-1:0]            pick_idx;
  logic                     pick_vld;
  logic                     grant;
  logic                     b_hs;

  rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .req (m_AWVALID),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign m_BID   = {NUM_MASTERS{s_BID}};
  assign m_BRESP = {NUM_MASTERS{s_BRESP}};

  // Grant is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    b_hs      = 1'b0;
    m_AWREADY = '0;
    m_WREADY  = '0;
    m_BVALID  = '0;
    s_AWVALID = 1'b0;
    s_WVALID  = 1'b0;
    s_WDATA   = '0;
    s_WSTRB   = '0;
    s_WLAST   = 1'b0;
    s_BREADY  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld && !axi_ARESET) begin
          grant     = 1'b1;
          m_AWREADY = pick_gnt;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        s_AWVALID = 1'b1;
        if (s_AWREADY) state_d = DATA;
      end
      DATA: begin
        s_WVALID          = m_WVALID[owner_q];
        s_WDATA           = m_WDATA[owner_q*DATA_WIDTH +: DATA_WIDTH];
        s_WSTRB           = m_WSTRB[owner_q*STROBE_WIDTH +: STROBE_WIDTH];
        s_WLAST           = m_WLAST[owner_q];
        m_WREADY[owner_q] = s_WREADY;
        if (s_WVALID && s_WREADY && s_WLAST) state_d = RESP;
      end
      RESP: begin
        m_BVALID[owner_q] = s_BVALID;
        s_BREADY          = m_BREADY[owner_q];
        if (s_BVALID && s_BREADY) begin
          b_hs    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_ACLK or posedge axi_ARESET) begin
    if (axi_ARESET) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      s_AWID    <= '0;
      s_AWADDR  <= '0;
      s_AWLEN   <= '0;
      s_AWSIZE  <= '0;
      s_AWBURST <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q   <= pick_idx;
        s_AWID    <= m_AWID[pick_idx*ID_WIDTH +: ID_WIDTH];
        s_AWADDR  <= m_AWADDR[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
        s_AWLEN   <= m_AWLEN[pick_idx*LEN_WIDTH +: LEN_WIDTH];
        s_AWSIZE  <= m_AWSIZE[pick_idx*SIZE_WIDTH +: SIZE_WIDTH];
        s_AWBURST <= m_AWBURST[pick_idx*BURST_WIDTH +: BURST_WIDTH];
      end
      if (b_hs) rr_ptr_q <= (owner_q == IW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
    end
  end

`ifdef AXI_WR_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_MASTERS];

  always_ff @(posedge axi_ACLK or posedge axi_ARESET) begin
    if (axi_ARESET) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) cnt_q[i] <= '0;
    end else if (grant && (cnt_q[pick_idx] != '1)) begin
      cnt_q[pick_idx] <= cnt_q[pick_idx] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cnt
    assign grant_cnt[gi*16 +: 16] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: two master drivers, a slave/memory model and a bus monitor.
module tb_axi_wr_arbiter;
  import axi_pkg::*;

  localparam int NM = 2, AW = 16, DW = 32, LW = 8, SW = 3, BW = 2, RW = 2, IDW = 4, STW = 4;
  localparam int MAX_WAIT = 500;

  logic axi_tb_ACLK = 1'b0;
  logic axi_tb_ARESET;

  logic [NM-1:0]     m_AWVALID, m_AWREADY, m_WVALID, m_WREADY, m_WLAST, m_BVALID, m_BREADY;
  logic [NM*IDW-1:0] m_AWID, m_BID;
  logic [NM*AW-1:0]  m_AWADDR;
  logic [NM*LW-1:0]  m_AWLEN;
  logic [NM*SW-1:0]  m_AWSIZE;
  logic [NM*BW-1:0]  m_AWBURST;
  logic [NM*DW-1:0]  m_WDATA;
  logic [NM*STW-1:0] m_WSTRB;
  logic [NM*RW-1:0]  m_BRESP;
  logic              s_AWVALID, s_AWREADY, s_WVALID, s_WREADY, s_WLAST, s_BVALID, s_BREADY;
  logic [IDW-1:0]    s_AWID, s_BID;
  logic [AW-1:0]     s_AWADDR;
  logic [LW-1:0]     s_AWLEN;
  logic [SW-1:0]     s_AWSIZE;
  logic [BW-1:0]     s_AWBURST;
  logic [DW-1:0]     s_WDATA;
  logic [STW-1:0]    s_WSTRB;
  logic [RW-1:0]     s_BRESP;
`ifdef AXI_WR_ARB_STATS_EN
  logic [NM*16-1:0]  grant_cnt;
`endif

  logic           mv_awvalid [NM];
  logic [IDW-1:0] mv_awid    [NM];
  logic [AW-1:0]  mv_awaddr  [NM];
  logic [LW-1:0]  mv_awlen   [NM];
  logic [SW-1:0]  mv_awsize  [NM];
  logic [BW-1:0]  mv_awburst [NM];
  logic           mv_wvalid  [NM];
  logic           mv_wlast   [NM];
  logic [DW-1:0]  mv_wdata   [NM];
  logic [STW-1:0] mv_wstrb   [NM];
  logic           mv_bready  [NM];

  always_comb begin
    m_AWVALID = '0; m_AWID = '0; m_AWADDR = '0; m_AWLEN = '0; m_AWSIZE = '0; m_AWBURST = '0;
    m_WVALID = '0; m_WLAST = '0; m_WDATA = '0; m_WSTRB = '0; m_BREADY = '0;
    for (int i = 0; i < NM; i++) begin
      m_AWVALID[i]            = mv_awvalid[i];
      m_AWID[i*IDW +: IDW]    = mv_awid[i];
      m_AWADDR[i*AW +: AW]    = mv_awaddr[i];
      m_AWLEN[i*LW +: LW]     = mv_awlen[i];
      m_AWSIZE[i*SW +: SW]    = mv_awsize[i];
      m_AWBURST[i*BW +: BW]   = mv_awburst[i];
      m_WVALID[i]             = mv_wvalid[i];
      m_WLAST[i]              = mv_wlast[i];
      m_WDATA[i*DW +: DW]     = mv_wdata[i];
      m_WSTRB[i*STW +: STW]   = mv_wstrb[i];
      m_BREADY[i]             = mv_bready[i];
    end
  end

  axi_wr_arbiter #(
    .NUM_MASTERS (NM), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .LEN_WIDTH (LW), .SIZE_WIDTH (SW),
    .BURST_WIDTH (BW), .RESP_WIDTH (RW), .ID_WIDTH (IDW), .STROBE_WIDTH (STW)
  ) dut (
    .axi_ACLK (axi_tb_ACLK), .axi_ARESET (axi_tb_ARESET),
    .m_AWVALID (m_AWVALID), .m_AWREADY (m_AWREADY), .m_AWID (m_AWID), .m_AWADDR (m_AWADDR),
    .m_AWLEN (m_AWLEN), .m_AWSIZE (m_AWSIZE), .m_AWBURST (m_AWBURST),
    .m_WVALID (m_WVALID), .m_WREADY (m_WREADY), .m_WLAST (m_WLAST), .m_WDATA (m_WDATA),
    .m_WSTRB (m_WSTRB), .m_BVALID (m_BVALID), .m_BREADY (m_BREADY), .m_BID (m_BID),
    .m_BRESP (m_BRESP), .s_AWVALID (s_AWVALID), .s_AWREADY (s_AWREADY), .s_AWID (s_AWID),
    .s_AWADDR (s_AWADDR), .s_AWLEN (s_AWLEN), .s_AWSIZE (s_AWSIZE), .s_AWBURST (s_AWBURST),
    .s_WVALID (s_WVALID), .s_WREADY (s_WREADY), .s_WDATA (s_WDATA), .s_WSTRB (s_WSTRB),
    .s_WLAST (s_WLAST), .s_BVALID (s_BVALID), .s_BREADY (s_BREADY), .s_BID (s_BID),
    .s_BRESP (s_BRESP)
`ifdef AXI_WR_ARB_STATS_EN
    , .grant_cnt (grant_cnt)
`endif
  );

  initial forever #5 axi_tb_ACLK = ~axi_tb_ACLK;

  typedef struct { int m; logic [IDW-1:0] id; logic [AW-1:0] addr; logic [LW-1:0] len; } aw_exp_t;
  typedef struct { logic [DW-1:0] data; logic last; } w_exp_t;
  typedef struct { int m; logic [IDW-1:0] id; } b_exp_t;

  aw_exp_t aw_exp[$];
  w_exp_t  w_exp[$];
  b_exp_t  b_exp[$];
  int      order_exp[$];

  int n_vec = 0, n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int m, input logic [AW-1:0] addr, input int i);
    return {4'(m), addr[11:0], 16'(i)};
  endfunction

  function automatic logic [NM-1:0] oh(input int i);
    logic [NM-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Slave / monitor state
  logic [DW-1:0] mem [256];
  int   cyc = 0, last_b_cyc = -1, aw_wait = 0, aw_delay = 0, cur_owner = 0, w_beats = 0;
  bit   w_toggle = 0, b_pend = 0, expect_awv = 0, gap_check = 0;
  logic [IDW-1:0] b_id = '0;
  logic [AW-1:0]  waddr = '0;

  initial begin
    aw_exp_t ae; w_exp_t we; b_exp_t be; int g;
    s_AWREADY = 0; s_WREADY = 0; s_BVALID = 0; s_BID = '0; s_BRESP = '0;
    forever begin
      @(negedge axi_tb_ACLK);
      if (axi_tb_ARESET) begin
        s_AWREADY = 0; s_WREADY = 0; s_BVALID = 0;
        b_pend = 0; aw_wait = 0; expect_awv = 0; last_b_cyc = -1;
        aw_exp.delete(); w_exp.delete(); b_exp.delete();
      end else begin
        s_AWREADY = (aw_wait >= aw_delay);
        s_WREADY  = w_toggle ? cyc[0] : 1'b1;
        s_BVALID  = b_pend;
        s_BID     = b_id;
        s_BRESP   = OKAY;
        #2;
        cyc++;
        if (expect_awv) begin
          check_eq("aw_latency", s_AWVALID, 1);
          expect_awv = 0;
        end
        if (|(m_AWVALID & m_AWREADY)) begin
          g = 0;
          for (int i = 0; i < NM; i++) if (m_AWVALID[i] && m_AWREADY[i]) g = i;
          check_eq("grant_onehot", m_AWVALID & m_AWREADY, oh(g));
          if (order_exp.size() > 0) check_eq("grant_order", g, order_exp.pop_front());
          if (gap_check && last_b_cyc >= 0) check_eq("rearb_gap", cyc - last_b_cyc, 1);
          expect_awv = 1;
        end
        if (s_AWVALID) begin
          check_eq("aw_exp_avail", aw_exp.size() > 0, 1);
          if (aw_exp.size() > 0) begin
            ae = aw_exp[0];
            check_eq("aw_fields", {s_AWID, s_AWADDR, s_AWLEN}, {ae.id, ae.addr, ae.len});
            check_eq("aw_size_burst", {s_AWSIZE, s_AWBURST}, {3'd2, INCR});
            if (s_AWREADY) begin
              void'(aw_exp.pop_front());
              cur_owner = ae.m; waddr = s_AWADDR; b_id = s_AWID; aw_wait = 0;
            end else begin
              aw_wait++;
            end
          end
        end
        if (|m_WVALID) check_eq("wready_others", m_WREADY & ~oh(cur_owner), '0);
        if (s_WVALID && s_WREADY) begin
          check_eq("w_exp_avail", w_exp.size() > 0, 1);
          if (w_exp.size() > 0) begin
            we = w_exp.pop_front();
            check_eq("w_data", s_WDATA, we.data);
            check_eq("w_last", s_WLAST, we.last);
            check_eq("w_strb", s_WSTRB, 4'hF);
            check_eq("w_ready_owner", m_WREADY, oh(cur_owner));
          end
          mem[waddr[9:2]] = s_WDATA;
          waddr = waddr + 16'd4;
          w_beats++;
          if (s_WLAST) b_pend = 1;
        end
        if (s_BVALID && s_BREADY) begin
          check_eq("b_exp_avail", b_exp.size() > 0, 1);
          if (b_exp.size() > 0) begin
            be = b_exp.pop_front();
            check_eq("b_valid_route", m_BVALID, oh(be.m));
            check_eq("b_id", m_BID[be.m*IDW +: IDW], be.id);
            check_eq("b_resp", m_BRESP[be.m*RW +: RW], OKAY);
          end
          b_pend = 0;
          last_b_cyc = cyc;
        end
      end
    end
  end

  task automatic run_master(input int m, input logic [AW-1:0] addr, input int len,
                            input logic [IDW-1:0] id);
    int cyc_n = 0;
    int beat = 0;
    bit aw_done = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    aw_exp_t ae; w_exp_t we; b_exp_t be;
    mv_awid[m] = id; mv_awaddr[m] = addr; mv_awlen[m] = LW'(len);
    mv_awsize[m] = 3'd2; mv_awburst[m] = INCR; mv_awvalid[m] = 1'b1;
    mv_wdata[m] = beat_data(m, addr, 0); mv_wstrb[m] = '1;
    mv_wlast[m] = (len == 0); mv_wvalid[m] = 1'b1;
    while (!(aw_done && beat > len) && cyc_n < MAX_WAIT && !axi_tb_ARESET) begin
      #1;
      aw_hs = mv_awvalid[m] && m_AWREADY[m];
      w_hs  = mv_wvalid[m] && m_WREADY[m];
      if (aw_hs) begin
        ae.m = m; ae.id = id; ae.addr = addr; ae.len = LW'(len);
        aw_exp.push_back(ae);
        for (int i = 0; i <= len; i++) begin
          we.data = beat_data(m, addr, i); we.last = (i == len);
          w_exp.push_back(we);
        end
        be.m = m; be.id = id;
        b_exp.push_back(be);
      end
      @(negedge axi_tb_ACLK);
      cyc_n++;
      if (aw_hs) begin mv_awvalid[m] = 1'b0; aw_done = 1; end
      if (w_hs) begin
        beat++;
        if (beat <= len) begin
          mv_wdata[m] = beat_data(m, addr, beat);
          mv_wlast[m] = (beat == len);
        end else begin
          mv_wvalid[m] = 1'b0;
        end
      end
    end
    if (axi_tb_ARESET) begin
      mv_awvalid[m] = 1'b0; mv_wvalid[m] = 1'b0;
      return;
    end
    check_eq($sformatf("m%0d_wr_done", m), aw_done && beat > len, 1);
    mv_awvalid[m] = 1'b0; mv_wvalid[m] = 1'b0;
    mv_bready[m] = 1'b1;
    cyc_n = 0;
    while (!b_hs && cyc_n < MAX_WAIT && !axi_tb_ARESET) begin
      #1;
      b_hs = m_BVALID[m];
      @(negedge axi_tb_ACLK);
      cyc_n++;
    end
    mv_bready[m] = 1'b0;
    if (!axi_tb_ARESET) check_eq($sformatf("m%0d_b_done", m), b_hs, 1);
  endtask

  task automatic do_reset();
    @(negedge axi_tb_ACLK);
    axi_tb_ARESET = 1'b1;
    order_exp.delete();
    repeat (2) @(negedge axi_tb_ACLK);
    axi_tb_ARESET = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_awready"}, m_AWREADY, '0);
    check_eq({tag, "_wready"}, m_WREADY, '0);
    check_eq({tag, "_bvalid"}, m_BVALID, '0);
    check_eq({tag, "_s_awvalid"}, s_AWVALID, 0);
    check_eq({tag, "_s_aw_fields"}, {s_AWID, s_AWADDR, s_AWLEN, s_AWSIZE, s_AWBURST}, '0);
    check_eq({tag, "_s_wvalid"}, s_WVALID, 0);
    check_eq({tag, "_s_bready"}, s_BREADY, 0);
`ifdef AXI_WR_ARB_STATS_EN
    check_eq({tag, "_grant_cnt"}, grant_cnt, '0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, n_miss %0d expected 0", n_miss);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int waited;
    for (int i = 0; i < NM; i++) begin
      mv_awvalid[i] = 0; mv_awid[i] = '0; mv_awaddr[i] = '0; mv_awlen[i] = '0;
      mv_awsize[i] = '0; mv_awburst[i] = '0; mv_wvalid[i] = 0; mv_wlast[i] = 0;
      mv_wdata[i] = '0; mv_wstrb[i] = '0; mv_bready[i] = 0;
    end
    axi_tb_ARESET = 1'b1;
    repeat (3) @(negedge axi_tb_ACLK);
    axi_tb_ARESET = 1'b0;
    #1;
    check_outputs_zero("reset");
    @(negedge axi_tb_ACLK);

    // Single 8-beat burst from master 0, then memory readback
    order_exp.push_back(0);
    base = w_beats;
    run_master(0, 16'h0000, 7, 4'hA);
    repeat (2) @(negedge axi_tb_ACLK);
    check_eq("t1_beats", w_beats - base, 8);
    for (int i = 0; i < 8; i++) check_eq("t1_mem", mem[i], beat_data(0, 16'h0000, i));

    // Simultaneous request after reset, then three round-robin rounds
    do_reset();
    gap_check = 1;
    order_exp.push_back(0); order_exp.push_back(1);
    fork
      run_master(0, 16'h0100, 3, 4'h1);
      run_master(1, 16'h0200, 3, 4'h2);
    join
    for (int r = 0; r < 3; r++) begin order_exp.push_back(0); order_exp.push_back(1); end
    fork
      for (int r = 0; r < 3; r++) run_master(0, 16'h0400 + 16'(r * 64), 2, 4'h3);
      for (int r = 0; r < 3; r++) run_master(1, 16'h0600 + 16'(r * 64), 2, 4'h4);
    join
    check_eq("t3_order_drained", order_exp.size(), 0);
    gap_check = 0;

    // Slow slave: AWREADY held off, WREADY toggling; master 1 presents W early
    aw_delay = 5; w_toggle = 1;
    order_exp.push_back(0); order_exp.push_back(1);
    base = w_beats;
    fork
      run_master(0, 16'h0800, 7, 4'h5);
      run_master(1, 16'h0900, 3, 4'h6);
    join
    check_eq("t4_beats", w_beats - base, 12);
    aw_delay = 0; w_toggle = 0;

    // Reset during beat 3 of 8, then a clean burst from master 1
    @(negedge axi_tb_ACLK);
    order_exp.push_back(0);
    base = w_beats;
    fork
      run_master(0, 16'h0300, 7, 4'h7);
      begin
        waited = 0;
        while ((w_beats - base) < 3 && waited < MAX_WAIT) begin
          @(negedge axi_tb_ACLK);
          waited++;
        end
        check_eq("t5_reach_beat3", w_beats - base, 3);
        #3 axi_tb_ARESET = 1'b1;
        #1 check_outputs_zero("midrst");
        order_exp.delete();
        repeat (2) @(negedge axi_tb_ACLK);
        axi_tb_ARESET = 1'b0;
      end
    join
    @(negedge axi_tb_ACLK);
    order_exp.push_back(1);
    run_master(1, 16'h00F0, 7, 4'h9);
    repeat (2) @(negedge axi_tb_ACLK);
    for (int i = 0; i < 8; i++) check_eq("t5_mem", mem[60 + i], beat_data(1, 16'h00F0, i));

`ifdef AXI_WR_ARB_STATS_EN
    do_reset();
    for (int r = 0; r < 2; r++) begin order_exp.push_back(0); order_exp.push_back(1); end
    fork
      for (int r = 0; r < 2; r++) run_master(0, 16'h0A00 + 16'(r * 32), 1, 4'h1);
      for (int r = 0; r < 2; r++) run_master(1, 16'h0B00 + 16'(r * 32), 1, 4'h2);
    join
    order_exp.push_back(0); order_exp.push_back(0);
    run_master(0, 16'h0C00, 0, 4'h1);
    run_master(0, 16'h0C40, 0, 4'h1);
    #1 check_eq("grant_cnt", grant_cnt, {16'd2, 16'd4});
`endif

    repeat (2) @(negedge axi_tb_ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
